// File: rtl/ov7725_emu_if.sv
// DVP pixel bus driven by the OV7725 emulator: pixel clock, syncs and data byte.
interface ov7725_emu_if;
   logic       pclk;
   logic       vsync;
   logic       href;
   logic [7:0] dout;

   modport master (output pclk, output vsync, output href, output dout);
   modport slave  (input  pclk, input  vsync, input  href, input  dout);
endinterface

// File: rtl/ov7725_emu.sv
// OV7725 camera emulator: generates an RGB565 DVP stream (high byte first) with
// selectable test patterns. pclk = CLK/2; all bus outputs change on pclk falling edges.
module ov7725_emu #(
   parameter int unsigned H_ACTIVE = 320,
   parameter int unsigned H_BLANK  = 144,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BACK   = 18,
   parameter int unsigned V_ACTIVE = 240,
   parameter int unsigned V_FRONT  = 8
) (
   input  logic         CLK,
   input  logic         RST_X,
   input  logic         en,
   input  logic [1:0]   mode,
   input  logic [15:0]  solid_rgb,
   ov7725_emu_if.master dvp,
   output logic [7:0]   frame_cnt,
   output logic         frame_done
);
   localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned HW       = $clog2(LINE_LEN);
   localparam int unsigned HREF_END = 2 * H_ACTIVE;
   localparam int unsigned BAR_W    = H_ACTIVE / 8;

   typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_t;

   state_t        st_q, st_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [15:0]   vcnt_q, vcnt_d;
   logic          pclk_q, vsync_q, href_q;
   logic [7:0]    dout_q;
   logic [1:0]    mode_q;
   logic [15:0]   solid_q;
   logic          tick, frame_end, vsync_entry;
   logic [15:0]   state_lines;
   logic [15:0]   x, pix, bar_rgb;
   logic [7:0]    y;
   logic [2:0]    bar;
   logic          href_d;
   logic [7:0]    dout_d;

   // A tick is the CLK edge on which pclk falls.
   assign tick = pclk_q;

   // Number of lines the current state lasts
   always_comb begin
      case (st_q)
         StVsync:  state_lines = 16'(V_SYNC);
         StVback:  state_lines = 16'(V_BACK);
         StActive: state_lines = 16'(V_ACTIVE);
         StVfront: state_lines = 16'(V_FRONT);
         default:  state_lines = 16'd1;
      endcase
   end

   // Next line/frame position, applied only on ticks
   always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (st_q == StIdle) begin
         // hcnt/vcnt are already zero whenever the machine sits in idle
         if (en) st_d = StVsync;
      end else if (32'(hcnt_q) != LINE_LEN - 1) begin
         hcnt_d = hcnt_q + 1'b1;
      end else begin
         hcnt_d = '0;
         if (vcnt_q != state_lines - 16'd1) begin
            vcnt_d = vcnt_q + 16'd1;
         end else begin
            vcnt_d = '0;
            case (st_q)
               StVsync:  st_d = StVback;
               StVback:  st_d = StActive;
               StActive: st_d = StVfront;
               StVfront: st_d = en ? StVsync : StIdle;
               default:  st_d = StIdle;
            endcase
         end
      end
   end

   assign frame_end   = tick && (st_q == StVfront) && (st_d != StVfront);
   assign vsync_entry = tick && (st_d == StVsync) && (st_q != StVsync);

   // Pattern pixel and byte for the position reached after this tick
   always_comb begin
      x   = 16'(hcnt_d >> 1);
      y   = vcnt_d[7:0];
      bar = 3'(32'(x) / BAR_W);
      case (bar)
         3'd0:    bar_rgb = 16'hFFFF;
         3'd1:    bar_rgb = 16'hFFE0;
         3'd2:    bar_rgb = 16'h07FF;
         3'd3:    bar_rgb = 16'h07E0;
         3'd4:    bar_rgb = 16'hF81F;
         3'd5:    bar_rgb = 16'hF800;
         3'd6:    bar_rgb = 16'h001F;
         default: bar_rgb = 16'h0000;
      endcase
      case (mode_q)
         2'd0:    pix = bar_rgb;
         2'd1:    pix = {y, x[7:0]};
         2'd2:    pix = solid_q;
         default: pix = {frame_cnt, x[7:0]};
      endcase
      href_d = (st_d == StActive) && (32'(hcnt_d) < HREF_END);
      dout_d = href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
   end

   // Pixel clock, frame state machine, counters and registered bus outputs
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         pclk_q     <= 1'b0;
         st_q       <= StIdle;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         dout_q     <= 8'h00;
         mode_q     <= 2'd0;
         solid_q    <= 16'h0000;
         frame_cnt  <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         pclk_q     <= ~pclk_q;
         frame_done <= 1'b0;
         if (tick) begin
            st_q    <= st_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            vsync_q <= (st_d == StVsync);
            href_q  <= href_d;
            dout_q  <= dout_d;
            // Pattern settings are frozen for the whole frame
            if (vsync_entry) begin
               mode_q  <= mode;
               solid_q <= solid_rgb;
            end
            if (frame_end) begin
               frame_cnt  <= frame_cnt + 8'd1;
               frame_done <= 1'b1;
            end
         end
      end
   end

   assign dvp.pclk  = pclk_q;
   assign dvp.vsync = vsync_q;
   assign dvp.href  = href_q;
   assign dvp.dout  = dout_q;
endmodule

// File: tb/tb_ov7725_emu.sv
// Bench for ov7725_emu: reduced geometry, per-pclk comparison against a frame-position model.
module tb_ov7725_emu;
   localparam int H_ACTIVE = 8;
   localparam int H_BLANK  = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 1;
   localparam int V_ACTIVE = 3;
   localparam int V_FRONT  = 1;
   localparam int L        = 2 * H_ACTIVE + H_BLANK;
   localparam int FRAME    = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * L;

   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] solid_rgb = 16'h0000;
   logic [7:0]  frame_cnt;
   logic        frame_done;

   ov7725_emu_if dvp ();

   ov7725_emu #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT)
   ) dut (
      .CLK        (CLK),
      .RST_X      (RST_X),
      .en         (en),
      .mode       (mode),
      .solid_rgb  (solid_rgb),
      .dvp        (dvp),
      .frame_cnt  (frame_cnt),
      .frame_done (frame_done)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int exp_fc = 0;

   // frame_done is one CLK wide, so each pulse is seen on exactly one falling CLK edge
   always @(negedge CLK) if (frame_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next point where pclk is high (mid pixel, data stable)
   task automatic next_sample();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (dvp.pclk !== 1'b1 && n < 4);
   endtask

   function automatic logic [15:0] bar_val(input int b);
      case (b)
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   // Expected {vsync, href, dout} at pclk period t of a frame (t=0 is the first vsync period)
   function automatic logic [9:0] model(input int t, input int md, input logic [15:0] sol,
                                        input logic [7:0] fc);
      int line, h, x, y;
      logic [15:0] pix;
      logic [9:0] r;
      line = t / L;
      h    = t % L;
      r    = '0;
      r[9] = (line < V_SYNC);
      if (line >= V_SYNC + V_BACK && line < V_SYNC + V_BACK + V_ACTIVE && h < 2 * H_ACTIVE) begin
         x = h / 2;
         y = line - V_SYNC - V_BACK;
         case (md)
            0: pix = bar_val(x / (H_ACTIVE / 8));
            1: pix = {8'(y), 8'(x)};
            2: pix = sol;
            default: pix = {fc, 8'(x)};
         endcase
         r[8]   = 1'b1;
         r[7:0] = (h % 2 == 0) ? pix[15:8] : pix[7:0];
      end
      return r;
   endfunction

   // Check one whole frame; inputs are scrambled mid-frame and set for the next frame near the end
   task automatic run_frame(input int md, input logic [15:0] sol, input int junk_md,
                            input logic [15:0] junk_sol, input int nxt_md,
                            input logic [15:0] nxt_sol, input int drop_t);
      int n = 0;
      int d0;
      logic [9:0] exp, obs;
      while (dvp.vsync !== 1'b1 && n < 2 * FRAME) begin
         next_sample();
         n++;
      end
      chk("frame_start", 32'(dvp.vsync), 32'd1);
      d0 = done_cnt;
      for (int t = 0; t < FRAME; t++) begin
         exp = model(t, md, sol, exp_fc[7:0]);
         obs = {dvp.vsync, dvp.href, dvp.dout};
         chk($sformatf("stream md=%0d fc=%0d t=%0d", md, exp_fc, t), 32'(obs), 32'(exp));
         if (t == FRAME / 2) begin
            mode      = 2'(junk_md);
            solid_rgb = junk_sol;
         end
         if (t == drop_t) en = 1'b0;
         if (t == FRAME - 2) begin
            mode      = 2'(nxt_md);
            solid_rgb = nxt_sol;
         end
         next_sample();
      end
      exp_fc = (exp_fc + 1) % 256;
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      chk("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("vsync_after_frame", 32'(dvp.vsync), 32'(en));
   endtask

   // Release reset on a falling CLK edge and check the start-up edge sequence
   task automatic release_reset();
      RST_X = 1'b1;
      @(negedge CLK);
      chk("rel_pclk_rise", 32'(dvp.pclk), 32'd1);
      chk("rel_vsync_low", 32'(dvp.vsync), 32'd0);
      @(negedge CLK);
      chk("rel_pclk_tick", 32'(dvp.pclk), 32'd0);
      chk("rel_vsync_rise", 32'(dvp.vsync), 32'd1);
      next_sample();
      exp_fc = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pclk"}, 32'(dvp.pclk), 32'd0);
      chk({tag, "_bus"}, 32'({dvp.vsync, dvp.href, dvp.dout}), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      int md;
      logic [15:0] sol;
      int d0;

      en   = 1'b1;
      mode = 2'd1;
      repeat (3) @(negedge CLK);
      chk_reset_outputs("reset");
      release_reset();

      // Coordinate, colour bars, then solid with a mid-line solid_rgb change
      run_frame(1, 16'h0, 1, 16'h0, 0, 16'h0, -1);
      run_frame(0, 16'h0, 2, 16'($urandom), 2, 16'hA5C3, -1);
      run_frame(2, 16'hA5C3, 2, 16'h1234, 0, 16'h0, -1);

      md  = 0;
      sol = 16'h0;
      for (int f = 0; f < 3; f++) begin
         int nmd = int'($urandom_range(0, 3));
         logic [15:0] nsol = 16'($urandom);
         run_frame(md, sol, int'($urandom_range(0, 3)), 16'($urandom), nmd, nsol, -1);
         md  = nmd;
         sol = nsol;
      end

      // Drop en during active line 1: frame completes, then idle
      run_frame(md, sol, int'($urandom_range(0, 3)), 16'($urandom), 3, 16'h0,
                (V_SYNC + V_BACK + 1) * L + 5);
      d0 = done_cnt;
      for (int i = 0; i < 40; i++) begin
         chk("idle_bus", 32'({dvp.vsync, dvp.href, dvp.dout}), 32'd0);
         next_sample();
      end
      chk("idle_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      chk("idle_no_done", 32'(done_cnt - d0), 32'd0);

      // Re-enable: vsync on the very next tick; this frame runs with frame_cnt=7
      en = 1'b1;
      @(negedge CLK);
      chk("reen_vsync", 32'(dvp.vsync), 32'd1);
      chk("reen_tick", 32'(dvp.pclk), 32'd0);
      next_sample();
      chk("fc_before_mode3", 32'(exp_fc), 32'd7);
      run_frame(3, 16'h0, 0, 16'($urandom), 3, 16'h0, -1);

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 20; i++) next_sample();
      @(negedge CLK);
      RST_X = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (4) @(negedge CLK);
      mode = 2'd3;
      release_reset();

      // 257 frames with mode 3: frame_cnt wraps back to 1
      for (int f = 0; f < 257; f++) begin
         run_frame(3, 16'h0, int'($urandom_range(0, 2)), 16'($urandom), 3, 16'($urandom), -1);
      end
      chk("wrap_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
